// File: rtl/apb_demux_timeout.sv
// Registered APB 1-to-N demultiplexer: decodes the upstream address into one of
// NUM_SLAVES contiguous regions and answers misses and hung completers with PSLVERR.
module apb_demux_timeout #(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    NUM_SLAVES     = 4,
  parameter int                    SLV_ADDR_BITS  = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h4000_0000,
  parameter int                    TIMEOUT_CYCLES = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADDR_WIDTH-1:0]            s_paddr_i,
  input  logic                             s_psel_i,
  input  logic                             s_penable_i,
  input  logic                             s_pwrite_i,
  input  logic [DATA_WIDTH-1:0]            s_pwdata_i,
  output logic                             s_pready_o,
  output logic                             s_pslverr_o,
  output logic [DATA_WIDTH-1:0]            s_prdata_o,
  output logic [ADDR_WIDTH-1:0]            m_paddr_o,
  output logic                             m_pwrite_o,
  output logic [DATA_WIDTH-1:0]            m_pwdata_o,
  output logic [NUM_SLAVES-1:0]            m_psel_o,
  output logic [NUM_SLAVES-1:0]            m_penable_o,
  input  logic [NUM_SLAVES-1:0]            m_pready_i,
  input  logic [NUM_SLAVES-1:0]            m_pslverr_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] m_prdata_i,
  output logic                             timeout_o
);

  localparam int IW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TMO_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  state_e                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic                    write_r, write_s;
  logic [DATA_WIDTH-1:0]   wdata_r, wdata_s;
  logic [IW-1:0]           idx_r, idx_s;
  logic [DATA_WIDTH-1:0]   rdata_r, rdata_s;
  logic                    slverr_r, slverr_s;
  logic                    tmo_r, tmo_s;
  logic [CW-1:0]           cnt_r, cnt_s;

  logic [ADDR_WIDTH-1:0]   off_s, idx_full_s;
  logic                    hit_s, setup_s, rdy_s, tmo_hit_s;
  logic [NUM_SLAVES-1:0]   sel_vec_s;

  logic                    s_pready_r, s_pready_s;
  logic                    s_pslverr_r, s_pslverr_s;
  logic [DATA_WIDTH-1:0]   s_prdata_r, s_prdata_s;
  logic [ADDR_WIDTH-1:0]   m_paddr_r, m_paddr_s;
  logic                    m_pwrite_r, m_pwrite_s;
  logic [DATA_WIDTH-1:0]   m_pwdata_r, m_pwdata_s;
  logic [NUM_SLAVES-1:0]   m_psel_r, m_psel_s;
  logic [NUM_SLAVES-1:0]   m_penable_r, m_penable_s;
  logic                    timeout_r, timeout_s;

  // Address decode and selected-completer status
  always_comb begin
    off_s      = s_paddr_i - BASE_ADDR;
    idx_full_s = off_s >> SLV_ADDR_BITS;
    hit_s      = (s_paddr_i >= BASE_ADDR) && (idx_full_s < ADDR_WIDTH'(NUM_SLAVES));
    setup_s    = s_psel_i & ~s_penable_i;
    rdy_s      = m_pready_i[idx_r];
    tmo_hit_s  = (TIMEOUT_CYCLES != 0) && (cnt_r == CW'(TMO_LIM));
  end

  // Next-state logic; a psel&penable seen in IDLE is a protocol violation and is ignored
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (setup_s) begin
          state_s = hit_s ? ST_SETUP : ST_ERR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP:  state_s = ST_ACCESS;
      ST_ACCESS: begin
        if (rdy_s || tmo_hit_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      ST_RESP:   state_s = ST_IDLE;
      ST_ERR:    state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // Transfer capture and watchdog; ready in the limit cycle takes priority over abort
  always_comb begin
    addr_s   = addr_r;
    write_s  = write_r;
    wdata_s  = wdata_r;
    idx_s    = idx_r;
    rdata_s  = rdata_r;
    slverr_s = slverr_r;
    tmo_s    = tmo_r;
    cnt_s    = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (setup_s) begin
          addr_s   = s_paddr_i;
          write_s  = s_pwrite_i;
          wdata_s  = s_pwdata_i;
          idx_s    = idx_full_s[IW-1:0];
          rdata_s  = '0;
          slverr_s = 1'b0;
          tmo_s    = 1'b0;
        end else begin
          tmo_s    = 1'b0;
        end
      end
      ST_SETUP: cnt_s = '0;
      ST_ACCESS: begin
        if (rdy_s) begin
          rdata_s  = write_r ? '0 : m_prdata_i[int'(idx_r)*DATA_WIDTH +: DATA_WIDTH];
          slverr_s = m_pslverr_i[idx_r];
          tmo_s    = 1'b0;
        end else if (tmo_hit_s) begin
          rdata_s  = '0;
          slverr_s = 1'b1;
          tmo_s    = 1'b1;
        end else begin
          cnt_s    = cnt_r + CW'(1);
        end
      end
      default: cnt_s = cnt_r;
    endcase
  end

  // Output values for the coming state, registered alongside it
  always_comb begin
    for (int k = 0; k < NUM_SLAVES; k++) begin
      sel_vec_s[k] = (idx_s == IW'(k));
    end
    s_pready_s  = 1'b0;
    s_pslverr_s = 1'b0;
    s_prdata_s  = '0;
    m_paddr_s   = '0;
    m_pwrite_s  = 1'b0;
    m_pwdata_s  = '0;
    m_psel_s    = '0;
    m_penable_s = '0;
    timeout_s   = 1'b0;
    case (state_s)
      ST_SETUP: begin
        m_psel_s   = sel_vec_s;
        m_paddr_s  = addr_s;
        m_pwrite_s = write_s;
        m_pwdata_s = wdata_s;
      end
      ST_ACCESS: begin
        m_psel_s    = sel_vec_s;
        m_penable_s = sel_vec_s;
        m_paddr_s   = addr_s;
        m_pwrite_s  = write_s;
        m_pwdata_s  = wdata_s;
      end
      ST_RESP: begin
        s_pready_s  = 1'b1;
        s_pslverr_s = slverr_s;
        s_prdata_s  = rdata_s;
        timeout_s   = tmo_s;
      end
      ST_ERR: begin
        s_pready_s  = 1'b1;
        s_pslverr_s = 1'b1;
      end
      default: s_pready_s = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_r      <= '0;
      write_r     <= 1'b0;
      wdata_r     <= '0;
      idx_r       <= '0;
      rdata_r     <= '0;
      slverr_r    <= 1'b0;
      tmo_r       <= 1'b0;
      cnt_r       <= '0;
      s_pready_r  <= 1'b0;
      s_pslverr_r <= 1'b0;
      s_prdata_r  <= '0;
      m_paddr_r   <= '0;
      m_pwrite_r  <= 1'b0;
      m_pwdata_r  <= '0;
      m_psel_r    <= '0;
      m_penable_r <= '0;
      timeout_r   <= 1'b0;
    end else begin
      addr_r      <= addr_s;
      write_r     <= write_s;
      wdata_r     <= wdata_s;
      idx_r       <= idx_s;
      rdata_r     <= rdata_s;
      slverr_r    <= slverr_s;
      tmo_r       <= tmo_s;
      cnt_r       <= cnt_s;
      s_pready_r  <= s_pready_s;
      s_pslverr_r <= s_pslverr_s;
      s_prdata_r  <= s_prdata_s;
      m_paddr_r   <= m_paddr_s;
      m_pwrite_r  <= m_pwrite_s;
      m_pwdata_r  <= m_pwdata_s;
      m_psel_r    <= m_psel_s;
      m_penable_r <= m_penable_s;
      timeout_r   <= timeout_s;
    end
  end

  assign s_pready_o  = s_pready_r;
  assign s_pslverr_o = s_pslverr_r;
  assign s_prdata_o  = s_prdata_r;
  assign m_paddr_o   = m_paddr_r;
  assign m_pwrite_o  = m_pwrite_r;
  assign m_pwdata_o  = m_pwdata_r;
  assign m_psel_o    = m_psel_r;
  assign m_penable_o = m_penable_r;
  assign timeout_o   = timeout_r;

endmodule

// File: tb/tb_apb_demux_timeout.sv
// Scoreboard bench for apb_demux_timeout: a driver pushes predicted responses,
// a monitor pops them whenever the upstream port signals pready.
module tb_apb_demux_timeout;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int          NS   = 4;
  localparam int          TMO  = 16;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [31:0]   s_paddr_i, s_pwdata_i;
  logic          s_psel_i, s_penable_i, s_pwrite_i;
  logic          s_pready_o, s_pslverr_o, m_pwrite_o, timeout_o;
  logic [31:0]   s_prdata_o, m_paddr_o, m_pwdata_o;
  logic [NS-1:0] m_psel_o, m_penable_o, m_pready_i, m_pslverr_i;
  logic [NS*32-1:0] m_prdata_i;

  apb_demux_timeout dut (
    .clk_i(clk), .rst_i(rst_i),
    .s_paddr_i(s_paddr_i), .s_psel_i(s_psel_i), .s_penable_i(s_penable_i),
    .s_pwrite_i(s_pwrite_i), .s_pwdata_i(s_pwdata_i),
    .s_pready_o(s_pready_o), .s_pslverr_o(s_pslverr_o), .s_prdata_o(s_prdata_o),
    .m_paddr_o(m_paddr_o), .m_pwrite_o(m_pwrite_o), .m_pwdata_o(m_pwdata_o),
    .m_psel_o(m_psel_o), .m_penable_o(m_penable_o),
    .m_pready_i(m_pready_i), .m_pslverr_i(m_pslverr_i), .m_prdata_i(m_prdata_i),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    logic        tmo;
    logic        hit;
    int          port;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [31:0] rmem [logic [31:0]];
  logic [31:0] cmem [logic [31:0]];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [3:0]  cur_sel = 4'b0;
  logic [31:0] cur_addr = 32'h0, cur_wdata = 32'h0;
  logic        cur_write = 1'b0;
  int          cur_wait = 0;
  int          acc_cnt [NS];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: region arithmetic, completer wait count and a word memory
  function automatic exp_t predict(input logic [31:0] a, input logic w, input logic [31:0] d,
                                   input int wt, input int t0);
    exp_t e;
    longint off;
    e.t0 = t0;
    off = longint'(a) - longint'(BASE);
    e.hit = (off >= 0) && (off / 4096 < NS);
    e.port = e.hit ? int'(off / 4096) : 0;
    e.tmo = 1'b0;
    if (!e.hit) begin
      e.rdata = 32'h0; e.slverr = 1'b1; e.lat = 1;
    end else if (wt >= TMO) begin
      e.rdata = 32'h0; e.slverr = 1'b1; e.tmo = 1'b1; e.lat = 2 + TMO;
    end else begin
      e.lat = 3 + wt;
      e.slverr = (a[11:8] == 4'hE);
      if (w) begin
        rmem[a] = d;
        e.rdata = 32'h0;
      end else begin
        e.rdata = rmem.exists(a) ? rmem[a] : (a ^ 32'h5A5A_5A5A);
      end
    end
    return e;
  endfunction

  // Behavioural completers: ready after cur_wait access cycles, noise otherwise
  always @(negedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (m_psel_o[k] && m_penable_o[k] && acc_cnt[k] == cur_wait) begin
        m_pready_i[k]  = 1'b1;
        m_pslverr_i[k] = (m_paddr_o[11:8] == 4'hE);
        if (m_pwrite_o) begin
          cmem[m_paddr_o] = m_pwdata_o;
          m_prdata_i[k*32 +: 32] = $urandom;
        end else begin
          m_prdata_i[k*32 +: 32] = cmem.exists(m_paddr_o) ? cmem[m_paddr_o] : (m_paddr_o ^ 32'h5A5A_5A5A);
        end
      end else begin
        m_pready_i[k]  = 1'b0;
        m_pslverr_i[k] = 1'($urandom_range(0, 1));
        m_prdata_i[k*32 +: 32] = $urandom;
      end
      acc_cnt[k] = (m_psel_o[k] && m_penable_o[k]) ? acc_cnt[k] + 1 : 0;
    end
  end

  // Monitor: pops the scoreboard on every upstream response, polices downstream buses
  always @(negedge clk) begin
    if (s_pready_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 64'(s_pready_o), 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
        chk("pslverr", 64'(s_pslverr_o), 64'(mon_e.slverr));
        chk("prdata", 64'(s_prdata_o), 64'(mon_e.rdata));
        chk("timeout", 64'(timeout_o), 64'(mon_e.tmo));
      end
    end else begin
      if (timeout_o === 1'b1) chk("timeout_no_pready", 64'(timeout_o), 64'd0);
      if (s_prdata_o !== 32'h0 && cyc > 1) chk("prdata_idle", 64'(s_prdata_o), 64'd0);
    end
    if (m_psel_o !== 4'b0 && cyc > 1) begin
      chk("psel_port", 64'(m_psel_o), 64'(cur_sel));
      chk("paddr", 64'(m_paddr_o), 64'(cur_addr));
      chk("pwrite", 64'(m_pwrite_o), 64'(cur_write));
      if (cur_write) chk("pwdata", 64'(m_pwdata_o), 64'(cur_wdata));
    end
  end

  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input int wt);
    exp_t e;
    int n;
    e = predict(a, w, d, wt, cyc);
    cur_sel   = e.hit ? (4'b0001 << e.port) : 4'b0;
    cur_addr  = a;
    cur_write = w;
    cur_wdata = d;
    cur_wait  = wt;
    sb_q.push_back(e);
    s_paddr_i = a; s_pwrite_i = w; s_pwdata_i = d;
    s_psel_i = 1'b1; s_penable_i = 1'b0;
    @(negedge clk);
    s_penable_i = 1'b1;
    chk("t1_psel", 64'(m_psel_o), 64'(cur_sel));
    chk("t1_penable", 64'(m_penable_o), 64'd0);
    n = 1;
    while (s_pready_o !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 2) chk("t2_penable", 64'(m_penable_o), 64'(cur_sel));
    end
    if (s_pready_o !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL resp_wait: no s_pready_o within %0d cycles for addr %0h", n, a);
    end
    @(negedge clk);
    s_psel_i = 1'b0; s_penable_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {55'd0, s_pready_o, s_pslverr_o, |s_prdata_o, |m_paddr_o, m_pwrite_o,
             |m_pwdata_o, |m_psel_o, |m_penable_o, timeout_o}, 64'd0);
  endtask

  logic [31:0] misses [4] = '{32'h4000_4000, 32'h3FFF_FFFC, 32'h0000_0010, 32'hFFFF_FFF0};

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] a;
    int r, wt;
    rst_i = 1'b1;
    s_paddr_i = 32'h0; s_pwdata_i = 32'h0;
    s_psel_i = 1'b0; s_penable_i = 1'b0; s_pwrite_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst_i = 1'b0;
    @(negedge clk);

    xfer(32'h4000_1008, 1'b1, 32'hDEAD_BEEF, 0);
    xfer(32'h4000_3004, 1'b1, 32'h1234_5678, 0);
    xfer(32'h4000_3004, 1'b0, 32'h0, 3);
    xfer(32'h4000_1008, 1'b0, 32'h0, 1);
    xfer(32'h4000_4000, 1'b0, 32'h0, 0);
    xfer(32'h3FFF_FFFC, 1'b0, 32'h0, 0);
    xfer(32'h4000_2000, 1'b0, 32'h0, 1000);
    xfer(32'h4000_0004, 1'b0, 32'h0, 0);
    xfer(32'h4000_0008, 1'b0, 32'h0, TMO - 1);
    xfer(32'h4000_2E00, 1'b0, 32'h0, 2);

    // psel&penable without a setup phase must be ignored
    cur_sel = 4'b0;
    s_paddr_i = 32'h4000_0000; s_psel_i = 1'b1; s_penable_i = 1'b1;
    @(negedge clk);
    chk("violation_1", {62'd0, s_pready_o, |m_psel_o}, 64'd0);
    s_psel_i = 1'b0; s_penable_i = 1'b0;
    @(negedge clk);
    chk("violation_2", {62'd0, s_pready_o, |m_psel_o}, 64'd0);

    // reset while the completer is stalled in the access phase
    cur_sel = 4'b0100; cur_addr = 32'h4000_2010; cur_write = 1'b0; cur_wait = 1000;
    s_paddr_i = 32'h4000_2010; s_pwrite_i = 1'b0; s_psel_i = 1'b1; s_penable_i = 1'b0;
    @(negedge clk);
    s_penable_i = 1'b1;
    repeat (2) @(negedge clk);
    chk("pre_reset_penable", 64'(m_penable_o), 64'(4'b0100));
    rst_i = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset_outputs");
    s_psel_i = 1'b0; s_penable_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    xfer(32'h4000_2010, 1'b0, 32'h0, 2);

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        a = misses[$urandom_range(0, 3)];
      end else begin
        a = BASE + ($urandom_range(0, 3) << 12) + ($urandom_range(0, 15) << 2)
                 + (($urandom_range(0, 3) == 0) ? 32'hE00 : 32'h0);
      end
      r = $urandom_range(0, 9);
      wt = (r < 7) ? $urandom_range(0, 4) : (r == 7) ? TMO - 1 : (r == 8) ? TMO : 1000;
      xfer(a, 1'($urandom_range(0, 1)), $urandom, wt);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
